// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle wide adder that reuses one 4-bit carry-lookahead
// slice. Each clock adds one nibble, starting at the least significant nibble.
// The carry between nibbles is held in a register.
// A request is accepted only in IDLE. DONE lasts one cycle, and the registered
// sum/cout outputs are stable during that cycle.
// Optional feature: define CLA_SEQ_OVF_EN to add the signed-overflow output ovf.

// 4-bit carry-lookahead adder slice.
module cla_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Bitwise generate and propagate terms.
  for (genvar gi = 0; gi < 4; gi++) begin : g_gp
    assign g[gi] = a[gi] & b[gi];
    assign p[gi] = a[gi] ^ b[gi];
  end

  // Lookahead carry equations, flattened so that no carry ripples.
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c;
  end

endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef CLA_SEQ_OVF_EN
  logic               ovf_q, ovf_d;
  logic               c_msb;
`endif

  logic [3:0]         a_nib [N];
  logic [3:0]         b_nib [N];
  logic [3:0]         slice_a;
  logic [3:0]         slice_b;
  logic [3:0]         slice_s;
  logic               slice_cout;
  logic [WIDTH-1:0]   res_upd;
  logic               last;

  // Split the latched operands into nibbles. The current nibble is selected by idx.
  for (genvar gi = 0; gi < N; gi++) begin : g_nib
    assign a_nib[gi] = a_q[4*gi +: 4];
    assign b_nib[gi] = b_q[4*gi +: 4];
    // This is the result register with nibble idx replaced by the slice output.
    assign res_upd[4*gi +: 4] = (idx_q == IDX_W'(gi)) ? slice_s : res_q[4*gi +: 4];
  end

  assign slice_a = a_nib[idx_q];
  assign slice_b = b_nib[idx_q];
  assign last    = (idx_q == IDX_W'(N - 1));

  cla_4b u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

`ifdef CLA_SEQ_OVF_EN
  // Recover the carry into bit 3 of the top nibble: s3 = a3 ^ b3 ^ c3.
  assign c_msb = slice_a[3] ^ slice_b[3] ^ slice_s[3];
`endif

  // Next-state logic and datapath updates for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_upd;
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (last) begin
          // The full result, including the top nibble, goes straight to the outputs.
          sum_d   = res_upd;
          cout_d  = slice_cout;
`ifdef CLA_SEQ_OVF_EN
          ovf_d   = c_msb ^ slice_cout;
`endif
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // All outputs are decoded from registers only.
  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
`ifdef CLA_SEQ_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed testbench for cla_seq_adder with WIDTH=16.
// Define CLA_SEQ_OVF_EN to also check the overflow output.
module tb_cla_seq_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .done  (done),
    .sum   (sum),
`ifdef CLA_SEQ_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Issue one add and wait for done.
  // Checks the latency, the ready-low window and the results.
  task automatic do_add(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tcin, input logic [15:0] esum, input logic ecout,
                        input logic eovf);
    int edges;
    int rdy_low;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tcin;
    @(posedge clk);                 // accepting edge E0
    @(negedge clk);
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    edges = 0;
    rdy_low = 0;
    while (!done && edges < 20) begin
      if (!ready) rdy_low++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    if (!ready) rdy_low++;
    check({tag, "_latency"}, edges, 32'd4);
    check({tag, "_ready_low"}, rdy_low, 32'd5);
    check({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
`ifdef CLA_SEQ_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
`else
    if (eovf === 1'bx) $display("unused overflow expectation");
`endif
    @(negedge clk);
    check({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
    check({tag, "_done_single"}, {31'd0, done}, 32'd0);
    $display("txn %s a=0x%04h b=0x%04h cin=%0d -> sum=0x%04h cout=%0d", tag, ta, tb, tcin, sum, cout);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Hold reset for two cycles, then check the idle outputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum", {16'd0, sum}, 32'h0000);
    check("reset_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;

    // Directed vectors.
    do_add("basic",      16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_add("ripple",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_add("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    do_add("mixed",      16'h8421, 16'h1248, 1'b1, 16'h966A, 1'b0, 1'b0);
    do_add("ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_add("ovf_neg",    16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Busy rejection: a start pulse during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; a = 16'h0011; b = 16'h0022; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 16'hAAAA; b = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        dones++;
        check("busy_sum", {16'd0, sum}, 32'h0033);
      end
      @(negedge clk);
    end
    check("busy_done_count", dones, 32'd1);
    $display("txn busy a=0x0011 b=0x0022 (ignored 0xAAAA+0x5555) -> sum=0x%04h dones=%0d", sum, dones);

    // Assert reset after two RUN edges. No done may follow.
    @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(posedge clk);                 // E0
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);                 // E1
    @(posedge clk);                 // E2
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_sum", {16'd0, sum}, 32'h0000);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("midrst_no_done", dones, 32'd0);
    $display("txn midrst a=0x1111 b=0x2222 aborted -> sum=0x%04h dones=%0d", sum, dones);

    do_add("after_rst", 16'h0009, 16'h0009, 1'b0, 16'h0012, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle wide adder controller that sequences one `cla_4b` slice to add two WIDTH-bit operands, one nibble per clock. The carry is registered between nibbles. It exists for area-constrained datapaths that need wide adds without instantiating WIDTH/4 lookahead slices. It sits between a requesting master (start/ready/done handshake) and a single shared `cla_4b` instance, which it instantiates internally.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8; N = WIDTH/4 nibble steps
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only on an edge where ready=1
- a  input  WIDTH  operand A; sampled on the accepting edge
- b  input  WIDTH  operand B; sampled on the accepting edge
- cin  input  1  carry-in; sampled on the accepting edge
- ready  output  1  high only in IDLE
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out of the MSB nibble
- ovf  output  1  signed overflow; present only with CLA_SEQ_OVF_EN

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch a, b and cin into internal registers; clear nibble index idx to 0; go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN: the `cla_4b` slice adds nibble idx of A, nibble idx of B and the carry register.
  - Each edge writes the 4-bit result into nibble idx of the internal result register.
  - Each edge loads the slice Cout into the carry register and increments idx.
- RUN, on the edge where idx = N-1:
  - copy the full result to sum and the final carry to cout;
  - go to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
- start is ignored in RUN and DONE. Operands are not re-sampled and there is no queueing.
- sum/cout/ovf hold their last values until the next completion.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). Carry propagates across nibble boundaries only through the carry register.
- Reset, including mid-operation: state=IDLE, idx=0, carry=0, sum=0, cout=0, done=0, ovf=0, ready=1. Any in-flight operation is discarded and no done is issued for it.

## Timing
- The accepting edge is E0. RUN occupies edges E1..EN. done is high during the cycle after edge EN; for WIDTH=16, that is the 4th edge after E0.
- ready falls in the cycle after E0. ready is high again in the cycle after done.
- Throughput: one operation per N+2 cycles.
- Back-to-back: start held high continuously is accepted on the first IDLE edge after DONE.
- sum, cout and ovf change only on the edge that enters DONE, so they are stable whenever done=1.
- There are no combinational paths from inputs to outputs.

## Configuration
- CLA_SEQ_OVF_EN defined:
  - port ovf exists;
  - on DONE entry, ovf = (carry into the MSB of the top nibble) XOR (final carry-out);
  - the carry into the MSB is taken from the slice's internal bit-3 carry, or recomputed from the top nibble's bit 3.
- CLA_SEQ_OVF_EN undefined: port ovf and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=16, reset held 2 cycles -> ready=1, done=0, sum=0x0000, cout=0.
- Basic add: a=0x1234, b=0x4321, cin=0, start pulsed -> done exactly 4 edges after acceptance; sum=0x5555, cout=0; ready low for 5 cycles.
- Full ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Overflow (CLA_SEQ_OVF_EN):
  - a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1;
  - a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1;
  - a=0xFFFF, b=0x0001 -> ovf=0.
- Busy rejection: accept a=0x0011, b=0x0022, then pulse start with a=0xAAAA, b=0x5555 during RUN -> single done, sum=0x0033, no second done.
- Reset mid-RUN: assert rst for 1 cycle after 2 RUN edges -> no done, ready=1, sum=0. A subsequent a=0x0009, b=0x0009, cin=0 -> sum=0x0012.
